// File: rtl/fft_frame_buffer.sv
// Ping-pong frame store: captures the first KEEP bins of each FFT frame and streams them out over valid/ready.
// Optional drop counter enabled by the FFT_FRAME_BUFFER_DROP_CNT_EN macro (adds drop_count_clr / drop_count).
module fft_frame_buffer #(
  parameter int N        = 1024,
  parameter int KEEP     = N / 2,
  parameter int FP_WIDTH = 32,
  parameter int BW       = (KEEP > 1) ? $clog2(KEEP) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                source_valid,
  input  logic                source_sop,
  input  logic                source_eop,
  input  logic [FP_WIDTH-1:0] real_data_in,
  input  logic [FP_WIDTH-1:0] imag_data_in,
  output logic [FP_WIDTH-1:0] sample_real_data_out,
  output logic [FP_WIDTH-1:0] sample_imag_data_out,
  output logic [BW-1:0]       sample_bin,
  output logic                sample_last,
  output logic                data_valid,
  input  logic                data_ready,
  output logic [1:0]          bank_full,
  output logic                frame_dropped
`ifdef FFT_FRAME_BUFFER_DROP_CNT_EN
  ,
  input  logic                drop_count_clr,
  output logic [15:0]         drop_count
`endif
);

  localparam logic [BW:0] KEEP_C = (BW+1)'(KEEP);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} wstate_t;
  typedef enum logic {R_IDLE, R_STREAM} rstate_t;

  typedef struct packed {
    logic [FP_WIDTH-1:0] re;
    logic [FP_WIDTH-1:0] im;
    logic [BW-1:0]       bin;
    logic                last;
  } ent_t;

  logic [2*FP_WIDTH-1:0] mem [2][KEEP];
  logic [2*FP_WIDTH-1:0] rdata_q;

  wstate_t        wstate_q, wstate_d;
  rstate_t        rstate_q, rstate_d;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [BW:0]    count_q, count_d;
  logic [1:0][BW:0] len_q, len_d;
  logic [1:0]     bank_full_q, bank_full_d;
  logic           frame_dropped_q, frame_dropped_d;
  logic [BW:0]    raddr_q, raddr_d;
  logic           pend_q, pend_d;
  logic [BW-1:0]  pend_bin_q, pend_bin_d;
  logic           pend_last_q, pend_last_d;
  ent_t [1:0]     ent_q, ent_d;
  logic [1:0]     occ_q, occ_d;

  logic          wr_en, rd_en, pop, rd_last, push_slot;
  logic [BW-1:0] wr_addr, rd_addr;
  logic [1:0]    set_full, clr_full;
  logic [2:0]    fill;

  // Write side: the free check looks only at the registered bank_full.
  always_comb begin
    wstate_d        = wstate_q;
    wr_bank_d       = wr_bank_q;
    count_d         = count_q;
    len_d           = len_q;
    set_full        = 2'b00;
    frame_dropped_d = 1'b0;
    wr_en           = 1'b0;
    wr_addr         = '0;
    if (source_valid) begin
      if (source_sop) begin
        if (!bank_full_q[wr_bank_q]) begin
          wr_en    = 1'b1;
          count_d  = (BW+1)'(1);
          wstate_d = W_FILL;
        end else begin
          frame_dropped_d = 1'b1;
          wstate_d        = source_eop ? W_IDLE : W_DISCARD;
        end
      end else if (wstate_q == W_FILL) begin
        if (count_q < KEEP_C) begin
          wr_en   = 1'b1;
          wr_addr = count_q[BW-1:0];
          count_d = count_q + 1'b1;
        end
      end else if (wstate_q == W_DISCARD && source_eop) begin
        wstate_d = W_IDLE;
      end
      if (source_eop && wstate_d == W_FILL) begin
        len_d[wr_bank_q]    = count_d;
        set_full[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
        wstate_d            = W_IDLE;
      end
    end
  end

  assign pop       = data_valid & data_ready;
  assign fill      = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
  assign push_slot = (occ_q != {1'b0, pop});

  // Read side keeps at most two beats in flight (skid + RAM output) so it never overruns the skid.
  always_comb begin
    rstate_d  = rstate_q;
    rd_bank_d = rd_bank_q;
    raddr_d   = raddr_q;
    rd_en     = 1'b0;
    rd_addr   = '0;
    clr_full  = 2'b00;
    case (rstate_q)
      R_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          rstate_d = R_STREAM;
          rd_en    = 1'b1;
          raddr_d  = (BW+1)'(1);
        end
      end
      R_STREAM: begin
        if (raddr_q < len_q[rd_bank_q] && fill <= 3'd1) begin
          rd_en   = 1'b1;
          rd_addr = raddr_q[BW-1:0];
          raddr_d = raddr_q + 1'b1;
        end
        if (pop && ent_q[0].last) begin
          clr_full[rd_bank_q] = 1'b1;
          rd_bank_d           = ~rd_bank_q;
          rstate_d            = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign rd_last     = (({1'b0, rd_addr} + 1'b1) == len_q[rd_bank_q]);
  assign pend_d      = rd_en;
  assign pend_bin_d  = rd_addr;
  assign pend_last_d = rd_last;
  assign bank_full_d = (bank_full_q & ~clr_full) | set_full;

  always_comb begin
    ent_d = ent_q;
    occ_d = occ_q;
    if (pop) begin
      ent_d[0] = ent_q[1];
      occ_d    = occ_q - 1'b1;
    end
    if (pend_q) begin
      ent_d[push_slot] = {rdata_q, pend_bin_q, pend_last_q};
      occ_d            = occ_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank_q][wr_addr] <= {real_data_in, imag_data_in};
    if (rd_en) rdata_q <= mem[rd_bank_q][rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q        <= W_IDLE;
      rstate_q        <= R_IDLE;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      count_q         <= '0;
      len_q           <= '0;
      bank_full_q     <= 2'b00;
      frame_dropped_q <= 1'b0;
      raddr_q         <= '0;
      pend_q          <= 1'b0;
      pend_bin_q      <= '0;
      pend_last_q     <= 1'b0;
      ent_q           <= '0;
      occ_q           <= 2'd0;
    end else begin
      wstate_q        <= wstate_d;
      rstate_q        <= rstate_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      count_q         <= count_d;
      len_q           <= len_d;
      bank_full_q     <= bank_full_d;
      frame_dropped_q <= frame_dropped_d;
      raddr_q         <= raddr_d;
      pend_q          <= pend_d;
      pend_bin_q      <= pend_bin_d;
      pend_last_q     <= pend_last_d;
      ent_q           <= ent_d;
      occ_q           <= occ_d;
    end
  end

  assign sample_real_data_out = ent_q[0].re;
  assign sample_imag_data_out = ent_q[0].im;
  assign sample_bin           = ent_q[0].bin;
  assign sample_last          = ent_q[0].last;
  assign data_valid           = (occ_q != 2'd0);
  assign bank_full            = bank_full_q;
  assign frame_dropped        = frame_dropped_q;

`ifdef FFT_FRAME_BUFFER_DROP_CNT_EN
  logic [15:0] drop_count_q, drop_count_d;

  // Counts on the same edge that raises frame_dropped; clear has priority.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_count_clr)
      drop_count_d = 16'h0000;
    else if (frame_dropped_d && drop_count_q != 16'hFFFF)
      drop_count_d = drop_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_count_q <= 16'h0000;
    else     drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: queue scoreboard of expected output beats plus stall-stability checks.
module tb_fft_frame_buffer;
  localparam int N = 1024;
  localparam int KEEP = 512;
  localparam int FPW = 32;
  localparam int BW = 9;

  logic clk = 1'b0;
  logic rst;
  logic source_valid, source_sop, source_eop;
  logic [FPW-1:0] real_data_in, imag_data_in;
  logic [FPW-1:0] sample_real_data_out, sample_imag_data_out;
  logic [BW-1:0] sample_bin;
  logic sample_last, data_valid, data_ready;
  logic [1:0] bank_full;
  logic frame_dropped;
`ifdef FFT_FRAME_BUFFER_DROP_CNT_EN
  logic drop_count_clr;
  logic [15:0] drop_count;
`endif

  fft_frame_buffer #(.N(N), .KEEP(KEEP), .FP_WIDTH(FPW)) dut (
    .clk(clk), .rst(rst),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .real_data_in(real_data_in), .imag_data_in(imag_data_in),
    .sample_real_data_out(sample_real_data_out), .sample_imag_data_out(sample_imag_data_out),
    .sample_bin(sample_bin), .sample_last(sample_last),
    .data_valid(data_valid), .data_ready(data_ready),
    .bank_full(bank_full), .frame_dropped(frame_dropped)
`ifdef FFT_FRAME_BUFFER_DROP_CNT_EN
    , .drop_count_clr(drop_count_clr), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FPW-1:0] re;
    logic [FPW-1:0] im;
    logic [BW-1:0]  bin;
    logic           last;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int drop_seen = 0;
  int ready_mode = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ready pattern generator: 0 = always ready, 1 = 1-high/2-low, 2 = never ready.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0:       data_ready = 1'b1;
      1:       data_ready = (cyc % 3 == 0);
      default: data_ready = 1'b0;
    endcase
  end

  beat_t cur, saved;
  logic stall_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      cur = {sample_real_data_out, sample_imag_data_out, sample_bin, sample_last};
      if (frame_dropped) drop_seen++;
      if (stall_prev) begin
        check("stall_valid", 128'(data_valid), 128'(1));
        check("stall_hold", 128'(cur), 128'(saved));
      end
      if (data_valid && data_ready) begin
        check("q_nonempty", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) check($sformatf("beat%0d", acc_cnt), 128'(cur), 128'(q.pop_front()));
        acc_cnt++;
      end
      stall_prev = data_valid && !data_ready;
      saved = cur;
    end
  end

  function automatic logic [FPW-1:0] imag_of(input int v);
    return FPW'(v) ^ 32'h00A5_0000;
  endfunction

  task automatic beat(input logic s, input logic e, input int v);
    source_valid = 1'b1;
    source_sop = s;
    source_eop = e;
    real_data_in = FPW'(v);
    imag_data_in = imag_of(v);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int nbeats, input int restart, input int base,
                            input bit stored, input bit chk_drop);
    int s;
    int len;
    beat_t e;
    s = (restart > 0) ? restart : 0;
    len = (nbeats - s < KEEP) ? nbeats - s : KEEP;
    if (stored) begin
      for (int j = 0; j < len; j++) begin
        e.re = FPW'(base + s + j);
        e.im = imag_of(base + s + j);
        e.bin = BW'(j);
        e.last = (j == len - 1);
        q.push_back(e);
      end
    end
    for (int i = 0; i < nbeats; i++) begin
      beat(i == 0 || (restart > 0 && i == restart), i == nbeats - 1, base + i);
      if (chk_drop && i == 0) check("drop_pulse_hi", 128'(frame_dropped), 128'(1));
      if (chk_drop && i == 1) check("drop_pulse_lo", 128'(frame_dropped), 128'(0));
    end
    source_valid = 1'b0;
    source_sop = 1'b0;
    source_eop = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(q.size()), 128'(0));
    repeat (3) @(negedge clk);
    check({tag, "_bank_free"}, 128'(bank_full), 128'(0));
    check({tag, "_idle"}, 128'(data_valid), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int a0;
    int n;
    rst = 1'b1;
    source_valid = 1'b0;
    source_sop = 1'b0;
    source_eop = 1'b0;
    real_data_in = '0;
    imag_data_in = '0;
`ifdef FFT_FRAME_BUFFER_DROP_CNT_EN
    drop_count_clr = 1'b0;
`endif
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(data_valid), 128'(0));
    check("rst_bank_full", 128'(bank_full), 128'(0));
    check("rst_dropped", 128'(frame_dropped), 128'(0));
    check("rst_data", 128'({sample_real_data_out, sample_imag_data_out}), 128'(0));
    check("rst_bin_last", 128'({sample_bin, sample_last}), 128'(0));
    rst = 1'b0;

    // Single full frame, latency from eop edge to first valid.
    send_frame(N, 0, 0, 1, 0);
    check("lat_full_k", 128'(bank_full), 128'(2'b01));
    check("lat_valid_k", 128'(data_valid), 128'(0));
    @(posedge clk); #1;
    check("lat_valid_k1", 128'(data_valid), 128'(0));
    @(posedge clk); #1;
    check("lat_valid_k2", 128'(data_valid), 128'(1));
    check("lat_bin_k2", 128'(sample_bin), 128'(0));
    wait_drain(2000, "single_drain");

    // Backpressure 1-high/2-low.
    ready_mode = 1;
    send_frame(N, 0, 1000, 1, 0);
    wait_drain(3000, "bp_drain");
    ready_mode = 0;

    // Overflow: three back-to-back frames, consumer stalled.
    ready_mode = 2;
    send_frame(N, 0, 5000, 1, 0);
    send_frame(N, 0, 10000, 1, 0);
    check("ovf_full_after2", 128'(bank_full), 128'(2'b11));
    d0 = drop_seen;
    send_frame(N, 0, 20000, 0, 1);
    @(negedge clk);
    check("ovf_drop_count", 128'(drop_seen - d0), 128'(1));
    check("ovf_full_after3", 128'(bank_full), 128'(2'b11));
    ready_mode = 0;
    wait_drain(4000, "ovf_drain");

    // Short, restarted and single-beat frames.
    send_frame(100, 0, 30000, 1, 0);
    wait_drain(1000, "short_drain");
    send_frame(300, 50, 40000, 1, 0);
    wait_drain(1000, "restart_drain");
    send_frame(1, 0, 50000, 1, 0);
    wait_drain(100, "one_beat_drain");

    // Reset in the middle of the output stream.
    a0 = acc_cnt;
    send_frame(N, 0, 60000, 1, 0);
    n = 0;
    while (acc_cnt - a0 < 200 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", 128'(acc_cnt - a0 >= 200), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(data_valid), 128'(0));
    check("mid_rst_data", 128'({sample_real_data_out, sample_imag_data_out}), 128'(0));
    check("mid_rst_bin_last", 128'({sample_bin, sample_last}), 128'(0));
    check("mid_rst_bank_full", 128'(bank_full), 128'(0));
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(N, 0, 70000, 1, 0);
    check("post_rst_bank0", 128'(bank_full), 128'(2'b01));
    wait_drain(2000, "post_rst_drain");

`ifdef FFT_FRAME_BUFFER_DROP_CNT_EN
    ready_mode = 2;
    check("dc_start", 128'(drop_count), 128'(0));
    send_frame(4, 0, 80000, 1, 0);
    send_frame(4, 0, 80100, 1, 0);
    for (int k = 0; k < 3; k++) send_frame(4, 0, 80200 + k * 10, 0, 1);
    check("dc_three", 128'(drop_count), 128'(3));
    drop_count_clr = 1'b1;
    beat(1'b1, 1'b0, 80300);
    drop_count_clr = 1'b0;
    for (int i = 1; i < 4; i++) beat(1'b0, i == 3, 80300 + i);
    source_valid = 1'b0;
    source_eop = 1'b0;
    check("dc_clr_wins", 128'(drop_count), 128'(0));
    ready_mode = 0;
    wait_drain(200, "dc_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
